// File: rtl/fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_flex
//  Brief    : Valid/ready FIFO of any depth >= 2, optional registered output,
//             occupancy count, almost-full/almost-empty flags, sync flush.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_flex #(
    parameter int SIZEDATA  = 32,
    parameter int DEPTHFIFO = 8,
    parameter int REG_OUT   = 0,
    parameter int AF_TH     = 6,
    parameter int AE_TH     = 1,
    localparam int CAP      = DEPTHFIFO + REG_OUT,
    localparam int CW       = $clog2(CAP + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    input  logic [SIZEDATA-1:0] data_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [SIZEDATA-1:0] data_o,
    input  logic                ready_i,
    output logic [CW-1:0]       count_o,
    output logic                almost_full_o,
    output logic                almost_empty_o
);

    localparam int            PW         = (DEPTHFIFO > 1) ? $clog2(DEPTHFIFO) : 1;
    localparam logic [PW-1:0] c_ptr_last = PW'(DEPTHFIFO - 1);
    localparam logic [CW-1:0] c_cap      = CW'(CAP);
    localparam logic [CW-1:0] c_af_th    = CW'(AF_TH);
    localparam logic [CW-1:0] c_ae_th    = CW'(AE_TH);

    logic [SIZEDATA-1:0] r_mem [DEPTHFIFO];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_arr_wr;
    logic w_arr_rd;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == c_ptr_last) ? '0 : p + PW'(1);
    endfunction

    assign w_ready = (r_count < c_cap) & ~rst_i & ~flush_i;
    assign w_push  = valid_i & w_ready;
    assign w_pop   = w_valid & ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_arr_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_arr_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    // Array cleared on reset so the combinational read path shows zero afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTHFIFO; i++) r_mem[i] <= '0;
        end else if (w_arr_wr) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    generate
        if (REG_OUT == 0) begin : g_comb_out
            assign w_valid  = (r_count != '0);
            assign data_o   = r_mem[r_rd_ptr];
            assign w_arr_wr = w_push;
            assign w_arr_rd = w_pop;
        end else begin : g_reg_out
            logic                r_ovld;
            logic [SIZEDATA-1:0] r_odata;
            logic [CW-1:0]       w_arr_cnt;
            logic                w_arr_empty;
            logic                w_load;

            // The output register is always refilled first, so ovld=0 implies an empty array.
            assign w_arr_cnt   = r_count - CW'(r_ovld);
            assign w_arr_empty = (w_arr_cnt == '0);
            assign w_load      = ~r_ovld | w_pop;
            assign w_arr_rd    = w_load & ~w_arr_empty;
            assign w_arr_wr    = w_push & ~(w_load & w_arr_empty);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_ovld  <= 1'b0;
                    r_odata <= '0;
                end else if (flush_i) begin
                    r_ovld  <= 1'b0;
                end else if (w_load) begin
                    if (!w_arr_empty) begin
                        r_odata <= r_mem[r_rd_ptr];
                        r_ovld  <= 1'b1;
                    end else if (w_push) begin
                        r_odata <= data_i;
                        r_ovld  <= 1'b1;
                    end else begin
                        r_ovld  <= 1'b0;
                    end
                end
            end

            assign w_valid = r_ovld;
            assign data_o  = r_odata;
        end
    endgenerate

    assign ready_o        = w_ready;
    assign valid_o        = w_valid;
    assign count_o        = r_count;
    assign almost_full_o  = (r_count >= c_af_th);
    assign almost_empty_o = (r_count <= c_ae_th);

endmodule
`default_nettype wire

// File: tb/tb_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_flex
//  Brief    : Directed + random bench for fifo_flex, both output styles,
//             compared against queue-based occupancy/ordering models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_flex;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       ready_i = 1'b0;

    logic       rdy0, vld0, af0, ae0;
    logic [7:0] dat0;
    logic [2:0] cnt0;
    logic       rdy1, vld1, af1, ae1;
    logic [7:0] dat1;
    logic [2:0] cnt1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         prst = 1'b1;

    always #5 clk = ~clk;

    fifo_flex #(.SIZEDATA(8), .DEPTHFIFO(5), .REG_OUT(0), .AF_TH(4), .AE_TH(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .data_i(data_i),
        .ready_o(rdy0), .valid_o(vld0), .data_o(dat0), .ready_i(ready_i),
        .count_o(cnt0), .almost_full_o(af0), .almost_empty_o(ae0)
    );

    fifo_flex #(.SIZEDATA(8), .DEPTHFIFO(5), .REG_OUT(1), .AF_TH(5), .AE_TH(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .data_i(data_i),
        .ready_o(rdy1), .valid_o(vld1), .data_o(dat1), .ready_i(ready_i),
        .count_o(cnt1), .almost_full_o(af1), .almost_empty_o(ae1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string n, input int sz, input logic [7:0] head,
                             input int cap, input int af, input int ae,
                             input logic rdy, input logic vld, input logic [2:0] cnt,
                             input logic af_o, input logic ae_o, input logic [7:0] dat);
        chk({n, "_ready"}, 32'(rdy), 32'((sz < cap) && !rst && !flush));
        chk({n, "_valid"}, 32'(vld), 32'(sz != 0));
        chk({n, "_count"}, 32'(cnt), 32'(sz));
        chk({n, "_afull"}, 32'(af_o), 32'(sz >= af));
        chk({n, "_aempty"}, 32'(ae_o), 32'(sz <= ae));
        if (sz != 0)
            chk({n, "_data"}, 32'(dat), 32'(head));
        else if (prst)
            chk({n, "_data_rst"}, 32'(dat), 32'(0));
    endtask

    // One clock: drive at negedge, check model vs DUT, then advance the model at posedge.
    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit fl, input bit rs);
        bit push0, pop0, push1, pop1;
        @(negedge clk);
        valid_i = v; data_i = d; ready_i = r; flush = fl; rst = rs;
        #1;
        check_dut("d0", q0.size(), (q0.size() != 0) ? q0[0] : 8'h00, 5, 4, 1,
                  rdy0, vld0, cnt0, af0, ae0, dat0);
        check_dut("d1", q1.size(), (q1.size() != 0) ? q1[0] : 8'h00, 6, 5, 2,
                  rdy1, vld1, cnt1, af1, ae1, dat1);
        push0 = v && (q0.size() < 5) && !rs && !fl;
        pop0  = (q0.size() != 0) && r;
        push1 = v && (q1.size() < 6) && !rs && !fl;
        pop1  = (q1.size() != 0) && r;
        @(posedge clk);
        if (rs || fl) begin
            q0.delete();
            q1.delete();
        end else begin
            if (pop0)  void'(q0.pop_front());
            if (push0) q0.push_back(d);
            if (pop1)  void'(q1.pop_front());
            if (push1) q1.push_back(d);
        end
        prst = rs ? 1'b1 : (prst && !(push0 || push1) && !fl);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        #1;
        chk("t1_ready", 32'(rdy0), 32'(1));
        chk("t1_valid", 32'(vld0), 32'(0));
        chk("t1_count", 32'(cnt0), 32'(0));
        chk("t1_aempty", 32'(ae0), 32'(1));
        chk("t1_afull", 32'(af0), 32'(0));

        // Fill non-power-of-2 FIFO, overflow attempt
        for (int i = 0; i < 5; i++) step(1, 8'h11 + 8'(i), 0, 0, 0);
        #1;
        chk("t2_count", 32'(cnt0), 32'(5));
        chk("t2_ready", 32'(rdy0), 32'(0));
        chk("t2_afull", 32'(af0), 32'(1));
        step(1, 8'h16, 0, 0, 0);
        #1;
        chk("t2_count_hold", 32'(cnt0), 32'(5));
        chk("t2_cap_reg", 32'(cnt1), 32'(6));

        // Full with push and pop offered: pop only, then push next cycle
        step(1, 8'h17, 1, 0, 0);
        #1;
        chk("t3_pop_only", 32'(cnt0), 32'(4));
        step(1, 8'h18, 0, 0, 0);
        #1;
        chk("t3_refill", 32'(cnt0), 32'(5));
        repeat (8) step(0, 8'h00, 1, 0, 0);

        // Continuous streaming across pointer wraps
        for (int i = 0; i < 20; i++) step(1, 8'(i), (i > 0), 0, 0);
        #1;
        chk("t4_count", 32'(cnt0), 32'(1));
        repeat (3) step(0, 8'h00, 1, 0, 0);

        // Registered output: bypass, hold under back-pressure, full capacity
        step(1, 8'hA5, 0, 0, 0);
        #1;
        chk("t5_valid", 32'(vld1), 32'(1));
        chk("t5_data", 32'(dat1), 32'hA5);
        for (int i = 0; i < 6; i++) step(1, 8'hB0 + 8'(i), 0, 0, 0);
        #1;
        chk("t5_hold", 32'(dat1), 32'hA5);
        chk("t5_cap", 32'(cnt1), 32'(6));
        repeat (8) step(0, 8'h00, 1, 0, 0);

        // Flush beats simultaneous push/pop, then reset during pushes
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
        step(1, 8'hEE, 1, 1, 0);
        #1;
        chk("t6_flush_cnt0", 32'(cnt0), 32'(0));
        chk("t6_flush_cnt1", 32'(cnt1), 32'(0));
        chk("t6_flush_vld", 32'(vld1), 32'(0));
        for (int i = 0; i < 3; i++) step(1, 8'hD0 + 8'(i), 0, 0, 0);
        step(1, 8'hD8, 1, 0, 1);
        step(1, 8'hD9, 0, 0, 1);
        #1;
        chk("t6_rst_cnt", 32'(cnt0), 32'(0));
        chk("t6_rst_vld", 32'(vld0), 32'(0));

        // Randomised traffic, including sporadic flush and reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), 8'($urandom),
                 ($urandom_range(0, 9) < ((i / 50) % 2 == 0 ? 6 : 3)),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0));
        end
        repeat (8) step(0, 8'h00, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
